lap_stopwatch: RTL and testbench
================================

Name: lap_stopwatch

Overview:
- Parametrised successor of the single-channel 4-digit stopwatch. Supports 4–6 BCD time digits, count-up or count-down (timer) mode, and a lap/split hold that freezes the display while counting continues.
- Contains an internal tick prescaler, button edge detection, a BCD counter chain, a lap register and a multiplexed seven-segment scan driver.
- Everything runs on one clock domain using clock-enable strobes; there are no derived clocks.
- Sits between the debounced button inputs and the board display pins.

Parameters:
- CLK_HZ, 50000000, input clock frequency.
- TICK_HZ, 100, count rate (one LSB = 10 ms at the default).
- SCAN_HZ, 500, digit scan rate.
- NDIG, 4, number of time digits (4..6). Per-digit radix from LSB upward is 10, 10, 10, 6, 10, 6, i.e. hundredths, tenths, seconds, tens of seconds, minutes, tens of minutes.

Ports:
- clk, in, 1, system clock.
- rst, in, 1, asynchronous active-low reset.
- en, in, 1, block enable. 0 = display blanked, counting frozen, scan halted.
- start_stop, in, 1, debounced level. Rising edge toggles run.
- clear, in, 1, debounced level. Rising edge clears, or presets in down mode.
- lap, in, 1, debounced level. Rising edge toggles the lap hold.
- down, in, 1, mode select: 0 = count up, 1 = count down. Sampled only while stopped.
- preset, in, NDIG*4, BCD value loaded by clear in down mode.
- seg, out, 7, segments {g,f,e,d,c,b,a}, active-low.
- an_n, out, NDIG, digit enables, active-low, one-hot-cold.
- count, out, NDIG*4, live BCD count (not affected by lap hold).
- running, out, 1, run flag.
- lap_active, out, 1, display is showing the frozen lap value.
- expired, out, 1, countdown reached zero.

Behaviour:
- Reset (rst=0, asynchronous): count=0, lap register=0, running=0, lap_active=0, expired=0, mode register=up, prescalers=0, scan index=0, an_n=all 1, seg=7'h7F.
- Edge detectors: one register per button; pulse = level & ~prev. Each pulse is exactly 1 clk. Holding a button produces no repeat pulse.
- Tick:
  - Prescaler counts 0..CLK_HZ/TICK_HZ-1 and asserts tick for 1 clk at terminal count, then wraps to 0.
  - Counts only when running=1 and en=1. It is reset to 0 on clear and on every start.
  - First increment therefore lands exactly CLK_HZ/TICK_HZ cycles after the start pulse.
- Counter, up mode: on tick, digit0 increments. Digit k increments when all lower digits sit at radix-1. Full-scale wraps to all-zero and keeps running; expired stays 0.
- Counter, down mode: on tick, digit0 decrements with borrow (0 goes to radix-1).
  - A tick that makes count==0 sets expired=1 and running=0 in the same cycle.
  - A start pulse while count==0 in down mode is ignored.
- Start/stop pulse: running toggles. The mode register loads from down only on a stop-to-run transition.
- Clear pulse:
  - count = preset if the down input is 1, otherwise 0.
  - running=0, lap_active=0, expired=0, prescaler=0.
  - Also latches the mode register from down.
  - Preset digits exceeding their radix are saturated to radix-1.
- Lap pulse:
  - If lap_active=0: lap register = count (value after any same-cycle tick), lap_active=1.
  - If lap_active=1: lap_active=0.
  - Lap works whether running or stopped.
- Simultaneous pulses: clear > start_stop > lap. Lower-priority pulses in the same cycle are discarded. A tick coinciding with clear is discarded. A tick coinciding with stop is applied.
- Display:
  - Scan prescaler produces a strobe every CLK_HZ/(SCAN_HZ*NDIG) cycles. On each strobe the scan index advances 0..NDIG-1 and wraps.
  - an_n[i]=0 selects digit i; seg decodes the selected digit of (lap_active ? lap register : count).
  - Decimal point is not driven.
  - Registered output: seg/an_n update 1 clk after the strobe.
- en=0: an_n=all 1, seg=7'h7F, tick and scan frozen. Button pulses are still edge-detected and applied. Counter state is retained.
- Parameter checks: CLK_HZ/TICK_HZ ≥ 2 and NDIG in 4..6 are enforced by elaboration-time checks.

Test Plan:
- Bench parameters CLK_HZ=1000, TICK_HZ=100, NDIG=4, up mode. Start, wait 1000 clk → count=16'h0100, running=1. Stop → count holds across 50 further clk.
- Preload by running to 16'h5998, then 2 ticks → 16'h5999 then 16'h0000. Wrap with no expired flag.
- down=1, preset=16'h0003, clear, start → count 0002, 0001, 0000 at 10-clk spacing. expired=1 and running=0 on the 0000 cycle. A further start is ignored.
- Lap at count 0042 while running → lap_active=1 and scanned digits show 0,0,4,2 while count keeps advancing. Second lap → display tracks count.
- Clear and start_stop pulsed in the same cycle while running → count=0, running=0. Assert rst mid-run → all outputs at reset values immediately, without waiting for a clock edge.
- en=0 while running → an_n=4'hF, seg=7'h7F, count frozen. en=1 → counting resumes from the same value.

Source files
------------

// File: rtl/lap_stopwatch_if.sv
// Control/display bundle between the button front-end, the stopwatch core
// and the board display pins. The core takes the slave view.
interface lap_stopwatch_if #(
  parameter int NDIG = 4
);
  logic              en;
  logic              start_stop;
  logic              clear;
  logic              lap;
  logic              down;
  logic [NDIG*4-1:0] preset;
  logic [6:0]        seg;
  logic [NDIG-1:0]   an_n;
  logic [NDIG*4-1:0] count;
  logic              running;
  logic              lap_active;
  logic              expired;

  modport master (
    output en, start_stop, clear, lap, down, preset,
    input  seg, an_n, count, running, lap_active, expired
  );

  modport slave (
    input  en, start_stop, clear, lap, down, preset,
    output seg, an_n, count, running, lap_active, expired
  );
endinterface

// File: rtl/lap_stopwatch.sv
// Lap stopwatch / countdown timer: tick prescaler, button edge detection,
// mixed-radix BCD counter, lap hold register and a scanned 7-segment driver.
// Everything runs on clk with clock-enable strobes.
module lap_stopwatch #(
  parameter int CLK_HZ  = 50000000,
  parameter int TICK_HZ = 100,
  parameter int SCAN_HZ = 500,
  parameter int NDIG    = 4
) (
  input  logic           clk,
  input  logic           rst,
  lap_stopwatch_if.slave bus
);
  localparam int TDIV     = CLK_HZ / TICK_HZ;
  localparam int SDIV_RAW = CLK_HZ / (SCAN_HZ * NDIG);
  localparam int SDIV     = (SDIV_RAW < 1) ? 1 : SDIV_RAW;
  localparam int TW       = (TDIV > 1) ? $clog2(TDIV) : 1;
  localparam int SW       = (SDIV > 1) ? $clog2(SDIV) : 1;
  localparam int IW       = $clog2(NDIG);
  localparam logic [TW-1:0] TDIV_M1 = TW'(TDIV - 1);
  localparam logic [SW-1:0] SDIV_M1 = SW'(SDIV - 1);

  generate
    if (TDIV < 2) begin : g_chk_tdiv
      $error("lap_stopwatch: CLK_HZ/TICK_HZ must be at least 2");
    end
    if (NDIG < 4 || NDIG > 6) begin : g_chk_ndig
      $error("lap_stopwatch: NDIG must be in 4..6");
    end
  endgenerate

  // Largest legal value of digit k (radix-1): tens of seconds/minutes are base 6.
  function automatic logic [3:0] radix_max(input int k);
    return (k == 3 || k == 5) ? 4'd5 : 4'd9;
  endfunction

  // Active-low {g,f,e,d,c,b,a}; non-decimal codes blank the digit.
  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = 7'h40;
      4'd1:    seg_of = 7'h79;
      4'd2:    seg_of = 7'h24;
      4'd3:    seg_of = 7'h30;
      4'd4:    seg_of = 7'h19;
      4'd5:    seg_of = 7'h12;
      4'd6:    seg_of = 7'h02;
      4'd7:    seg_of = 7'h78;
      4'd8:    seg_of = 7'h00;
      4'd9:    seg_of = 7'h10;
      default: seg_of = 7'h7F;
    endcase
  endfunction

  logic                  ss_prev_q, clr_prev_q, lap_prev_q;
  logic                  clr_p, ss_p, lap_p, tick, cnt_zero, carry;
  logic [NDIG-1:0][3:0]  cnt_q, cnt_d, lap_q, lap_d, tick_val, preset_sat, disp;
  logic                  running_q, running_d, lap_act_q, lap_act_d;
  logic                  expired_q, expired_d, mode_q, mode_d;
  logic [TW-1:0]         pre_q, pre_d;
  logic [SW-1:0]         scan_pre_q;
  logic [IW-1:0]         scan_q;
  logic [6:0]            seg_q;
  logic [NDIG-1:0]       an_q;

  // Clear beats start/stop beats lap; losers in the same cycle are dropped.
  assign clr_p    = bus.clear & ~clr_prev_q;
  assign ss_p     = bus.start_stop & ~ss_prev_q & ~clr_p;
  assign lap_p    = bus.lap & ~lap_prev_q & ~clr_p & ~(bus.start_stop & ~ss_prev_q);
  assign tick     = running_q & bus.en & (pre_q == TDIV_M1);
  assign cnt_zero = (cnt_q == '0);
  assign disp     = lap_act_q ? lap_q : cnt_q;

  // Button edge-detect history.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ss_prev_q  <= 1'b0;
      clr_prev_q <= 1'b0;
      lap_prev_q <= 1'b0;
    end else begin
      ss_prev_q  <= bus.start_stop;
      clr_prev_q <= bus.clear;
      lap_prev_q <= bus.lap;
    end
  end

  // Counter value one tick later: ripple carry (up) or borrow (down) through the digits.
  always_comb begin
    tick_val = cnt_q;
    carry    = 1'b1;
    for (int k = 0; k < NDIG; k++) begin
      if (carry) begin
        if (mode_q) begin
          if (cnt_q[k] == 4'd0) tick_val[k] = radix_max(k);
          else begin
            tick_val[k] = cnt_q[k] - 4'd1;
            carry       = 1'b0;
          end
        end else begin
          if (cnt_q[k] >= radix_max(k)) tick_val[k] = 4'd0;
          else begin
            tick_val[k] = cnt_q[k] + 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
  end

  // Out-of-range preset digits clamp to the digit's maximum.
  always_comb begin
    preset_sat = '0;
    for (int k = 0; k < NDIG; k++) begin
      preset_sat[k] = (bus.preset[k*4 +: 4] > radix_max(k)) ? radix_max(k)
                                                            : bus.preset[k*4 +: 4];
    end
  end

  // Next-state for counter, lap hold, run/mode/expiry flags and tick prescaler.
  always_comb begin
    cnt_d     = cnt_q;
    lap_d     = lap_q;
    running_d = running_q;
    lap_act_d = lap_act_q;
    expired_d = expired_q;
    mode_d    = mode_q;
    pre_d     = pre_q;
    if (running_q && bus.en) pre_d = tick ? '0 : pre_q + TW'(1);
    if (clr_p) begin
      cnt_d     = bus.down ? preset_sat : '0;
      running_d = 1'b0;
      lap_act_d = 1'b0;
      expired_d = 1'b0;
      pre_d     = '0;
      mode_d    = bus.down;
    end else begin
      if (tick) begin
        cnt_d = tick_val;
        if (mode_q && tick_val == '0) begin
          expired_d = 1'b1;
          running_d = 1'b0;
        end
      end
      if (ss_p) begin
        if (running_q) running_d = 1'b0;
        else if (!(bus.down && cnt_zero)) begin
          running_d = 1'b1;
          mode_d    = bus.down;
          pre_d     = '0;
        end
      end
      if (lap_p) begin
        if (!lap_act_q) begin
          lap_d     = cnt_d;
          lap_act_d = 1'b1;
        end else begin
          lap_act_d = 1'b0;
        end
      end
    end
  end

  // Core state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      lap_q     <= '0;
      running_q <= 1'b0;
      lap_act_q <= 1'b0;
      expired_q <= 1'b0;
      mode_q    <= 1'b0;
      pre_q     <= '0;
    end else begin
      cnt_q     <= cnt_d;
      lap_q     <= lap_d;
      running_q <= running_d;
      lap_act_q <= lap_act_d;
      expired_q <= expired_d;
      mode_q    <= mode_d;
      pre_q     <= pre_d;
    end
  end

  // Scan prescaler and digit index; both hold while disabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_pre_q <= '0;
      scan_q     <= '0;
    end else if (bus.en) begin
      if (scan_pre_q == SDIV_M1) begin
        scan_pre_q <= '0;
        scan_q     <= (scan_q == IW'(NDIG - 1)) ? '0 : scan_q + IW'(1);
      end else begin
        scan_pre_q <= scan_pre_q + SW'(1);
      end
    end
  end

  // Registered display pins; blanked while disabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg_q <= 7'h7F;
      an_q  <= '1;
    end else if (!bus.en) begin
      seg_q <= 7'h7F;
      an_q  <= '1;
    end else begin
      seg_q <= seg_of(disp[scan_q]);
      an_q  <= ~(NDIG'(1) << scan_q);
    end
  end

  assign bus.seg        = seg_q;
  assign bus.an_n       = an_q;
  assign bus.count      = cnt_q;
  assign bus.running    = running_q;
  assign bus.lap_active = lap_act_q;
  assign bus.expired    = expired_q;
endmodule

// File: tb/tb_lap_stopwatch.sv
// Scoreboarded bench for lap_stopwatch: directed scenarios plus random button
// traffic, checked against an arithmetic reference model.
module tb_lap_stopwatch;
  localparam int CLK_HZ  = 1000;
  localparam int TICK_HZ = 100;
  localparam int SCAN_HZ = 50;
  localparam int NDIG    = 4;
  localparam int TDIV    = CLK_HZ / TICK_HZ;
  localparam int SDIV    = CLK_HZ / (SCAN_HZ * NDIG);

  typedef struct {
    int cyc;
    int cnt;
    bit run;
    bit lapa;
    bit expd;
    bit en_prev;
    int sidx;
    int dval;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  lap_stopwatch_if #(.NDIG(NDIG)) bus ();

  lap_stopwatch #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .SCAN_HZ(SCAN_HZ), .NDIG(NDIG))
    dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int   nchk = 0;
  int   nerr = 0;
  int   cyc  = 0;
  exp_t sbq[$];

  bit          l_ss, l_clr, l_lap, l_dn, l_en;
  logic [15:0] l_pre;

  int m_val, m_lap, m_phase, m_encnt;
  bit m_run, m_lapa, m_exp, m_mode, p_ss, p_clr, p_lap;

  function automatic int radix(int k);
    return (k == 3 || k == 5) ? 6 : 10;
  endfunction

  function automatic int weight(int k);
    int w = 1;
    for (int j = 0; j < k; j++) w *= radix(j);
    return w;
  endfunction

  function automatic int full_scale();
    return weight(NDIG);
  endfunction

  function automatic logic [31:0] to_bcd(int v);
    logic [31:0] r = '0;
    for (int k = 0; k < NDIG; k++) r |= 32'((v / weight(k)) % radix(k)) << (4 * k);
    return r;
  endfunction

  function automatic int sat_val(logic [15:0] p);
    int v = 0;
    int d;
    for (int k = 0; k < NDIG; k++) begin
      d = int'(p[4*k +: 4]);
      if (d > radix(k) - 1) d = radix(k) - 1;
      v += d * weight(k);
    end
    return v;
  endfunction

  function automatic logic [6:0] tb_seg(int d);
    logic [6:0] lit;
    case (d)
      0: lit = 7'b0111111;
      1: lit = 7'b0000110;
      2: lit = 7'b1011011;
      3: lit = 7'b1001111;
      4: lit = 7'b1100110;
      5: lit = 7'b1101101;
      6: lit = 7'b1111101;
      7: lit = 7'b0000111;
      8: lit = 7'b1111111;
      9: lit = 7'b1101111;
      default: lit = 7'b0000000;
    endcase
    return ~lit;
  endfunction

  function automatic void chk(string name, logic [31:0] got, logic [31:0] want);
    nchk++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
    end
  endfunction

  function automatic void model_reset();
    m_val = 0; m_lap = 0; m_phase = 0; m_encnt = 0;
    m_run = 0; m_lapa = 0; m_exp = 0; m_mode = 0;
    p_ss = 0; p_clr = 0; p_lap = 0;
  endfunction

  // Monitor: after every edge, retire the expectation queued for that edge.
  always @(posedge clk) begin
    exp_t e;
    cyc++;
    #2;
    while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
      e = sbq.pop_front();
      chk("sb_stale", 32'(e.cyc), 32'(cyc));
    end
    if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
      e = sbq.pop_front();
      chk("count", bus.count, to_bcd(e.cnt));
      chk("flags", {bus.running, bus.lap_active, bus.expired}, {e.run, e.lapa, e.expd});
      if (!e.en_prev) begin
        chk("blank", {bus.an_n, bus.seg}, {4'hF, 7'h7F});
      end else begin
        chk("display",
            {bus.an_n, bus.seg},
            {~(4'b0001 << e.sidx), tb_seg((e.dval / weight(e.sidx)) % radix(e.sidx))});
      end
    end
  end

  // Apply current input levels for one cycle and queue the model's view of the next edge.
  task automatic step();
    exp_t e;
    bit ssp, clp, lpp, tick, was_run;
    int nv;
    bus.start_stop = l_ss;
    bus.clear      = l_clr;
    bus.lap        = l_lap;
    bus.down       = l_dn;
    bus.en         = l_en;
    bus.preset     = l_pre;
    clp = l_clr && !p_clr;
    ssp = l_ss && !p_ss && !clp;
    lpp = l_lap && !p_lap && !clp && !(l_ss && !p_ss);
    p_ss = l_ss; p_clr = l_clr; p_lap = l_lap;
    e.en_prev = l_en;
    e.sidx    = (m_encnt / SDIV) % NDIG;
    e.dval    = m_lapa ? m_lap : m_val;
    if (l_en) m_encnt++;
    tick = m_run && l_en && (m_phase == TDIV - 1);
    nv = m_val;
    if (tick) nv = m_mode ? (m_val + full_scale() - 1) % full_scale() : (m_val + 1) % full_scale();
    if (clp) begin
      m_val = l_dn ? sat_val(l_pre) : 0;
      m_run = 0; m_lapa = 0; m_exp = 0; m_phase = 0; m_mode = l_dn;
    end else begin
      if (m_run && l_en) m_phase = tick ? 0 : m_phase + 1;
      was_run = m_run;
      m_val = nv;
      if (tick && m_mode && nv == 0) begin
        m_exp = 1;
        m_run = 0;
      end
      if (ssp) begin
        if (was_run) m_run = 0;
        else if (!(l_dn && m_val == 0)) begin
          m_run = 1; m_mode = l_dn; m_phase = 0;
        end
      end
      if (lpp) begin
        if (!m_lapa) begin
          m_lap = nv; m_lapa = 1;
        end else m_lapa = 0;
      end
    end
    e.cyc = cyc + 1; e.cnt = m_val; e.run = m_run; e.lapa = m_lapa; e.expd = m_exp;
    sbq.push_back(e);
    @(negedge clk);
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic press_ss();  l_ss  = 1; step(); l_ss  = 0; endtask
  task automatic press_clr(); l_clr = 1; step(); l_clr = 0; endtask
  task automatic press_lap(); l_lap = 1; step(); l_lap = 0; endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] seen [NDIG];
    int v0;
    l_ss = 0; l_clr = 0; l_lap = 0; l_dn = 0; l_en = 1; l_pre = '0;
    bus.start_stop = 0; bus.clear = 0; bus.lap = 0; bus.down = 0; bus.en = 1; bus.preset = '0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    chk("rst_count", bus.count, 16'h0000);
    chk("rst_flags", {bus.running, bus.lap_active, bus.expired}, 3'b000);
    chk("rst_disp", {bus.an_n, bus.seg}, {4'hF, 7'h7F});
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Basic up count: 100 ticks of 10 clk each.
    press_ss();
    run(999);
    chk("up_999", bus.count, 16'h0099);
    run(1);
    chk("up_1000", bus.count, 16'h0100);
    chk("up_running", bus.running, 1'b1);
    press_ss();
    run(50);
    chk("stop_hold", bus.count, 16'h0100);
    chk("stop_flag", bus.running, 1'b0);

    // Full-scale wrap via a preset load followed by an up-mode start.
    l_dn = 1; l_pre = 16'h5998;
    press_clr();
    chk("preload", bus.count, 16'h5998);
    l_dn = 0;
    press_ss();
    run(10);
    chk("wrap_5999", bus.count, 16'h5999);
    run(10);
    chk("wrap_0000", bus.count, 16'h0000);
    chk("wrap_flags", {bus.running, bus.expired}, 2'b10);
    press_ss();

    // Countdown to expiry; restart at zero refused.
    l_dn = 1; l_pre = 16'h0003;
    press_clr();
    press_ss();
    run(10);
    chk("down_0002", bus.count, 16'h0002);
    run(10);
    chk("down_0001", bus.count, 16'h0001);
    run(10);
    chk("down_0000", bus.count, 16'h0000);
    chk("expire_flags", {bus.running, bus.expired}, 2'b01);
    press_ss();
    run(20);
    chk("start_at_zero", {bus.running, bus.count}, {1'b0, 16'h0000});

    // Saturating preset.
    l_pre = 16'hFFFF;
    press_clr();
    chk("preset_sat", bus.count, 16'h5999);

    // Lap hold while counting continues.
    l_dn = 0;
    press_clr();
    press_ss();
    for (int i = 0; i < 2000 && m_val != 42; i++) step();
    chk("lap_reach_42", bus.count, 16'h0042);
    press_lap();
    for (int i = 0; i < NDIG; i++) seen[i] = 7'h7F;
    for (int i = 0; i < 25; i++) begin
      step();
      for (int d = 0; d < NDIG; d++) if (bus.an_n == ~(4'b0001 << d)) seen[d] = bus.seg;
    end
    chk("lap_dig3", seen[3], tb_seg(0));
    chk("lap_dig2", seen[2], tb_seg(0));
    chk("lap_dig1", seen[1], tb_seg(4));
    chk("lap_dig0", seen[0], tb_seg(2));
    chk("lap_active", bus.lap_active, 1'b1);
    chk("lap_count_moves", bus.count > 16'h0042, 1'b1);
    press_lap();
    run(30);
    chk("lap_release", bus.lap_active, 1'b0);

    // Clear and start/stop in the same cycle while running.
    l_clr = 1; l_ss = 1; step(); l_clr = 0; l_ss = 0;
    chk("clr_ss_same", {bus.running, bus.count}, {1'b0, 16'h0000});

    // Asynchronous reset mid-run.
    press_ss();
    run(37);
    press_lap();
    run(3);
    #2 rst = 1'b0;
    #1;
    chk("arst_count", bus.count, 16'h0000);
    chk("arst_flags", {bus.running, bus.lap_active, bus.expired}, 3'b000);
    chk("arst_disp", {bus.an_n, bus.seg}, {4'hF, 7'h7F});
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Enable low freezes count and blanks the display.
    press_ss();
    run(23);
    v0 = m_val;
    l_en = 0;
    run(30);
    chk("en0_disp", {bus.an_n, bus.seg}, {4'hF, 7'h7F});
    chk("en0_frozen", bus.count, to_bcd(v0));
    l_en = 1;
    run(30);
    chk("en1_resume", bus.count, to_bcd(v0 + 3));

    // Random button traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) l_ss  = ~l_ss;
      if ($urandom_range(0, 59) == 0) l_clr = ~l_clr;
      if ($urandom_range(0, 19) == 0) l_lap = ~l_lap;
      if ($urandom_range(0, 49) == 0) l_dn  = ~l_dn;
      if ($urandom_range(0, 79) == 0) l_en  = ~l_en;
      if ($urandom_range(0, 99) == 0) begin
        l_pre[3:0]   = 4'($urandom_range(0, 15));
        l_pre[7:4]   = 4'($urandom_range(0, 15));
        l_pre[11:8]  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
        l_pre[15:12] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
      end
      step();
    end

    chk("sb_drain", 32'(sbq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
